// File: rtl/riscv_test_monitor_pkg.sv
// rtl/riscv_test_monitor_pkg.sv - shared types, field layouts and helpers for the test monitor
package riscv_test_monitor_pkg;

  localparam int TM_TEST_W  = 8;
  localparam int TM_REG_W   = 5;
  localparam int TM_DATA_W  = 32;
  localparam int TM_ENTRY_W = TM_TEST_W + TM_REG_W + 2 * TM_DATA_W;
  localparam int TM_FAIL_W  = TM_TEST_W + TM_REG_W + 3 * TM_DATA_W;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_CHECK   = 3'd2,
    ST_DONE    = 3'd3,
    ST_TIMEOUT = 3'd4
  } tm_state_e;

  // Field order matches the cfg_entry bus, MSB first.
  typedef struct packed {
    logic [TM_TEST_W-1:0] test_num;
    logic [TM_REG_W-1:0]  rd;
    logic [TM_DATA_W-1:0] mask;
    logic [TM_DATA_W-1:0] value;
  } tm_entry_t;

  typedef struct packed {
    logic [TM_TEST_W-1:0] test_num;
    logic [TM_REG_W-1:0]  rd;
    logic [TM_DATA_W-1:0] got;
    logic [TM_DATA_W-1:0] mask;
    logic [TM_DATA_W-1:0] exp_val;
  } tm_fail_t;

  function automatic logic tm_match(input logic [TM_DATA_W-1:0] got,
                                    input logic [TM_DATA_W-1:0] mask,
                                    input logic [TM_DATA_W-1:0] value);
    return ((got ^ value) & mask) == '0;
  endfunction

endpackage

// File: rtl/test_monitor_shadow_rf.sv
// rtl/test_monitor_shadow_rf.sv - 32x32 shadow of the CPU register file, x0 hardwired to zero
module test_monitor_shadow_rf
  import riscv_test_monitor_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [TM_REG_W-1:0]  waddr,
  input  logic [TM_DATA_W-1:0] wdata,
  input  logic [TM_REG_W-1:0]  raddr,
  output logic [TM_DATA_W-1:0] rdata
);

  logic [TM_DATA_W-1:0] regs_q [32];
  logic [TM_DATA_W-1:0] regs_d [32];

  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != '0)) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata = (raddr == '0) ? '0 : regs_q[raddr];

endmodule

// File: rtl/riscv_test_monitor.sv
// rtl/riscv_test_monitor.sv - expected-value table, flag-triggered compare FSM, watchdog and result counters
module riscv_test_monitor
  import riscv_test_monitor_pkg::*;
#(
  parameter int FLAG_REG       = 20,
  parameter int CHECK_DEPTH    = 64,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter bit STOP_ON_FAIL   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_we,
  input  logic [TM_REG_W-1:0]   wb_addr,
  input  logic [TM_DATA_W-1:0]  wb_data,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [TM_ENTRY_W-1:0] cfg_entry,
  input  logic                  start,
  output logic                  done,
  output logic                  timeout,
  output logic [15:0]           pass_cnt,
  output logic [15:0]           fail_cnt,
  output logic                  fail_valid,
  output logic [TM_FAIL_W-1:0]  fail_info
);

  localparam int PTR_W  = $clog2(CHECK_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

  tm_state_e             state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [CNT_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [WDOG_W-1:0]     wdog_q, wdog_d;
  logic [15:0]           pass_cnt_q, pass_cnt_d;
  logic [15:0]           fail_cnt_q, fail_cnt_d;
  logic                  fail_valid_q, fail_valid_d;
  tm_fail_t              fail_info_q, fail_info_d;
  logic                  cfg_ready_q, cfg_ready_d;

  tm_entry_t             tbl_mem [CHECK_DEPTH];
  tm_entry_t             cur_e;
  logic [PTR_W-1:0]      nxt_idx;
  logic [TM_TEST_W-1:0]  nxt_tn;
  logic [TM_DATA_W-1:0]  got;
  logic                  cfg_fire;
  logic                  flag_hit;
  logic                  at_end;
  logic                  last_entry;
  logic                  chk_pass;
  logic [CNT_W-1:0]      rd_ptr_inc;

  assign cfg_fire   = cfg_valid && cfg_ready_q;
  assign cur_e      = tbl_mem[rd_ptr_q[PTR_W-1:0]];
  assign nxt_idx    = rd_ptr_q[PTR_W-1:0] + PTR_W'(1);
  assign nxt_tn     = tbl_mem[nxt_idx].test_num;
  assign rd_ptr_inc = rd_ptr_q + CNT_W'(1);
  assign at_end     = (rd_ptr_q == count_q);
  assign last_entry = (rd_ptr_inc == count_q);
  assign chk_pass   = tm_match(got, cur_e.mask, cur_e.value);
  assign flag_hit   = wb_we && (wb_addr == TM_REG_W'(FLAG_REG)) &&
                      (wb_data == {{(TM_DATA_W-TM_TEST_W){1'b0}}, cur_e.test_num});

  test_monitor_shadow_rf u_shadow (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wb_we),
    .waddr (wb_addr),
    .wdata (wb_data),
    .raddr (cur_e.rd),
    .rdata (got)
  );

  // Table contents need no reset: count_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (cfg_fire) begin
      tbl_mem[count_q[PTR_W-1:0]] <= tm_entry_t'(cfg_entry);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        // A flag match beats a watchdog expiry landing on the same cycle.
        if (at_end)                                        state_d = ST_DONE;
        else if (flag_hit)                                 state_d = ST_CHECK;
        else if (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1))    state_d = ST_TIMEOUT;
      end
      ST_CHECK: begin
        if (!chk_pass && STOP_ON_FAIL)       state_d = ST_DONE;
        else if (last_entry)                 state_d = ST_DONE;
        else if (nxt_tn != cur_e.test_num)   state_d = ST_RUN;
      end
      ST_DONE:    state_d = ST_DONE;
      ST_TIMEOUT: state_d = ST_TIMEOUT;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    done       = (state_q == ST_DONE) || (state_q == ST_TIMEOUT);
    timeout    = (state_q == ST_TIMEOUT);
    cfg_ready  = cfg_ready_q;
    pass_cnt   = pass_cnt_q;
    fail_cnt   = fail_cnt_q;
    fail_valid = fail_valid_q;
    fail_info  = fail_info_q;
  end

  always_comb begin
    count_d      = count_q + CNT_W'(cfg_fire);
    cfg_ready_d  = (state_d == ST_IDLE) && (count_d < CNT_W'(CHECK_DEPTH));
    rd_ptr_d     = rd_ptr_q;
    wdog_d       = '0;
    pass_cnt_d   = pass_cnt_q;
    fail_cnt_d   = fail_cnt_q;
    fail_valid_d = fail_valid_q;
    fail_info_d  = fail_info_q;

    if (state_q == ST_RUN && !flag_hit) begin
      wdog_d = wdog_q + WDOG_W'(1);
    end

    if (state_q == ST_CHECK) begin
      rd_ptr_d = rd_ptr_inc;
      if (chk_pass) begin
        if (pass_cnt_q != 16'hFFFF) pass_cnt_d = pass_cnt_q + 16'd1;
      end else begin
        if (fail_cnt_q != 16'hFFFF) fail_cnt_d = fail_cnt_q + 16'd1;
        if (!fail_valid_q) begin
          fail_valid_d = 1'b1;
          fail_info_d  = '{test_num: cur_e.test_num, rd: cur_e.rd, got: got,
                            mask: cur_e.mask, exp_val: cur_e.value};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= '0;
      cfg_ready_q  <= 1'b0;
      rd_ptr_q     <= '0;
      wdog_q       <= '0;
      pass_cnt_q   <= '0;
      fail_cnt_q   <= '0;
      fail_valid_q <= 1'b0;
      fail_info_q  <= '0;
    end else begin
      count_q      <= count_d;
      cfg_ready_q  <= cfg_ready_d;
      rd_ptr_q     <= rd_ptr_d;
      wdog_q       <= wdog_d;
      pass_cnt_q   <= pass_cnt_d;
      fail_cnt_q   <= fail_cnt_d;
      fail_valid_q <= fail_valid_d;
      fail_info_q  <= fail_info_d;
    end
  end

endmodule

// File: tb/tb_riscv_test_monitor.sv
// tb/tb_riscv_test_monitor.sv - directed bench for riscv_test_monitor (normal and stop-on-fail instances)
module tb_riscv_test_monitor;

  logic         clk;
  logic         rst_n;
  logic         wb_we;
  logic [4:0]   wb_addr;
  logic [31:0]  wb_data;
  logic         cfg_valid;
  logic [76:0]  cfg_entry;
  logic         start;

  logic         d_cfg_ready, d_done, d_timeout, d_fail_valid;
  logic [15:0]  d_pass_cnt, d_fail_cnt;
  logic [108:0] d_fail_info;
  logic         s_cfg_ready, s_done, s_timeout, s_fail_valid;
  logic [15:0]  s_pass_cnt, s_fail_cnt;
  logic [108:0] s_fail_info;

  int n_cmp;
  int n_fail;

  riscv_test_monitor #(
    .FLAG_REG(20), .CHECK_DEPTH(64), .TIMEOUT_CYCLES(16), .STOP_ON_FAIL(1'b0)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .cfg_valid(cfg_valid), .cfg_ready(d_cfg_ready), .cfg_entry(cfg_entry), .start(start),
    .done(d_done), .timeout(d_timeout), .pass_cnt(d_pass_cnt), .fail_cnt(d_fail_cnt),
    .fail_valid(d_fail_valid), .fail_info(d_fail_info)
  );

  riscv_test_monitor #(
    .FLAG_REG(20), .CHECK_DEPTH(64), .TIMEOUT_CYCLES(64), .STOP_ON_FAIL(1'b1)
  ) u_sof (
    .clk(clk), .rst_n(rst_n), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .cfg_valid(cfg_valid), .cfg_ready(s_cfg_ready), .cfg_entry(cfg_entry), .start(start),
    .done(s_done), .timeout(s_timeout), .pass_cnt(s_pass_cnt), .fail_cnt(s_fail_cnt),
    .fail_valid(s_fail_valid), .fail_info(s_fail_info)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "bench time limit");
  end

  typedef struct {
    logic [7:0]  tn;
    logic [4:0]  rd;
    logic [31:0] rval;
    logic [31:0] mask;
    logic [31:0] expv;
    bit          pass;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    start     = 1'b0;
    wb_we     = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_push(input logic [7:0] tn, input logic [4:0] rd,
                          input logic [31:0] mask, input logic [31:0] val);
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_entry = {tn, rd, mask, val};
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic wb_write(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    wb_we   = 1'b1;
    wb_addr = addr;
    wb_data = data;
    @(negedge clk);
    wb_we = 1'b0;
  endtask

  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input bit use_sof, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      seen = use_sof ? s_done : d_done;
      if (seen) break;
    end
    chk(name, {127'd0, seen}, 128'd1);
  endtask

  vec_t vecs [6];

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    wb_we     = 1'b0;
    wb_addr   = '0;
    wb_data   = '0;
    cfg_valid = 1'b0;
    cfg_entry = '0;
    start     = 1'b0;

    vecs[0] = '{tn: 8'd5, rd: 5'd11, rval: 32'h11223344, mask: 32'h0000FF00, expv: 32'h00003300, pass: 1'b1};
    vecs[1] = '{tn: 8'd5, rd: 5'd11, rval: 32'h11223344, mask: 32'h0000FF00, expv: 32'h00004400, pass: 1'b0};
    vecs[2] = '{tn: 8'd9, rd: 5'd5,  rval: 32'h00000000, mask: 32'h00000000, expv: 32'hDEADBEEF, pass: 1'b1};
    vecs[3] = '{tn: 8'd3, rd: 5'd0,  rval: 32'hFFFFFFFF, mask: 32'hFFFFFFFF, expv: 32'h00000000, pass: 1'b1};
    vecs[4] = '{tn: 8'd4, rd: 5'd31, rval: 32'h80000000, mask: 32'h80000000, expv: 32'hFFFFFFFF, pass: 1'b1};
    vecs[5] = '{tn: 8'd6, rd: 5'd7,  rval: 32'h12345678, mask: 32'hFFFFFFFF, expv: 32'h12345679, pass: 1'b0};

    // Reset state, asserted asynchronously before any clock edge.
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_cfg_ready", {127'd0, d_cfg_ready}, 128'd0);
    chk("rst_done", {127'd0, d_done}, 128'd0);
    chk("rst_timeout", {127'd0, d_timeout}, 128'd0);
    chk("rst_pass_cnt", {112'd0, d_pass_cnt}, 128'd0);
    chk("rst_fail_cnt", {112'd0, d_fail_cnt}, 128'd0);
    chk("rst_fail_valid", {127'd0, d_fail_valid}, 128'd0);
    chk("rst_fail_info", {19'd0, d_fail_info}, 128'd0);
    do_reset();
    chk("cfg_ready_after_reset", {127'd0, d_cfg_ready}, 128'd1);

    for (int v = 0; v < 6; v++) begin
      logic [31:0]  got_exp;
      logic [108:0] info_exp;
      do_reset();
      cfg_push(vecs[v].tn, vecs[v].rd, vecs[v].mask, vecs[v].expv);
      start_pulse();
      wb_write(vecs[v].rd, vecs[v].rval);
      wb_write(5'd20, {24'd0, vecs[v].tn});
      wait_done($sformatf("vec%0d_done", v), 1'b0, 20);
      chk($sformatf("vec%0d_pass_cnt", v), {112'd0, d_pass_cnt}, vecs[v].pass ? 128'd1 : 128'd0);
      chk($sformatf("vec%0d_fail_cnt", v), {112'd0, d_fail_cnt}, vecs[v].pass ? 128'd0 : 128'd1);
      chk($sformatf("vec%0d_fail_valid", v), {127'd0, d_fail_valid}, vecs[v].pass ? 128'd0 : 128'd1);
      if (!vecs[v].pass) begin
        got_exp  = (vecs[v].rd == 5'd0) ? 32'd0 : vecs[v].rval;
        info_exp = {vecs[v].tn, vecs[v].rd, got_exp, vecs[v].mask, vecs[v].expv};
        chk($sformatf("vec%0d_fail_info", v), {19'd0, d_fail_info}, {19'd0, info_exp});
      end
    end

    // Three-entry program across two test numbers.
    do_reset();
    cfg_push(8'd1, 5'd11, 32'hFFFFFFFF, 32'h00000003);
    cfg_push(8'd1, 5'd12, 32'h000000FF, 32'h00000044);
    cfg_push(8'd2, 5'd10, 32'hFFFFFFFF, 32'h500000F8);
    start_pulse();
    wb_write(5'd11, 32'h00000003);
    wb_write(5'd12, 32'h11223344);
    wb_write(5'd20, 32'd1);
    repeat (3) @(negedge clk);
    chk("prog_mid_pass_cnt", {112'd0, d_pass_cnt}, 128'd2);
    chk("prog_mid_done", {127'd0, d_done}, 128'd0);
    wb_write(5'd10, 32'h500000F8);
    wb_write(5'd20, 32'd2);
    wait_done("prog_done", 1'b0, 10);
    chk("prog_pass_cnt", {112'd0, d_pass_cnt}, 128'd3);
    chk("prog_fail_cnt", {112'd0, d_fail_cnt}, 128'd0);
    chk("prog_timeout", {127'd0, d_timeout}, 128'd0);
    chk("prog_sof_pass_cnt", {112'd0, s_pass_cnt}, 128'd3);

    // Stop-on-fail: first of two test-1 entries fails.
    do_reset();
    cfg_push(8'd1, 5'd11, 32'hFFFFFFFF, 32'h00000009);
    cfg_push(8'd1, 5'd12, 32'hFFFFFFFF, 32'h00000000);
    start_pulse();
    wb_write(5'd11, 32'h00000003);
    wb_write(5'd20, 32'd1);
    wait_done("sof_done", 1'b1, 10);
    chk("sof_pass_cnt", {112'd0, s_pass_cnt}, 128'd0);
    chk("sof_fail_cnt", {112'd0, s_fail_cnt}, 128'd1);
    chk("sof_fail_info", {19'd0, s_fail_info},
        {19'd0, 8'd1, 5'd11, 32'h00000003, 32'hFFFFFFFF, 32'h00000009});
    wait_done("nosof_done", 1'b0, 10);
    chk("nosof_pass_cnt", {112'd0, d_pass_cnt}, 128'd1);
    chk("nosof_fail_cnt", {112'd0, d_fail_cnt}, 128'd1);

    // Watchdog: unknown flag value ignored, TIMEOUT exactly 16 edges after start.
    do_reset();
    cfg_push(8'd1, 5'd1, 32'h0, 32'h0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    wb_we   = 1'b1;
    wb_addr = 5'd20;
    wb_data = 32'd7;
    @(posedge clk);
    #1;
    wb_we = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    chk("wdog_early_done", {127'd0, d_done}, 128'd0);
    chk("wdog_early_timeout", {127'd0, d_timeout}, 128'd0);
    @(posedge clk);
    #1;
    chk("wdog_done", {127'd0, d_done}, 128'd1);
    chk("wdog_timeout", {127'd0, d_timeout}, 128'd1);
    chk("wdog_pass_cnt", {112'd0, d_pass_cnt}, 128'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("wdog_sticky", {127'd0, d_timeout}, 128'd1);

    // Table full after 64 entries, then reset while checking.
    do_reset();
    begin
      int xfers;
      xfers     = 0;
      cfg_entry = {8'd1, 5'd1, 32'h0, 32'h0};
      cfg_valid = 1'b1;
      for (int i = 0; i < 65; i++) begin
        @(negedge clk);
        if (d_cfg_ready) xfers++;
      end
      cfg_valid = 1'b0;
      chk("full_xfers", 128'(xfers), 128'd64);
      chk("full_cfg_ready", {127'd0, d_cfg_ready}, 128'd0);
    end
    start_pulse();
    wb_write(5'd20, 32'd1);
    repeat (5) @(negedge clk);
    chk("full_mid_pass_cnt", {112'd0, d_pass_cnt}, 128'd5);
    rst_n = 1'b0;
    #1;
    chk("midrst_cfg_ready", {127'd0, d_cfg_ready}, 128'd0);
    chk("midrst_done", {127'd0, d_done}, 128'd0);
    chk("midrst_pass_cnt", {112'd0, d_pass_cnt}, 128'd0);
    chk("midrst_fail_cnt", {112'd0, d_fail_cnt}, 128'd0);
    chk("midrst_fail_info", {19'd0, d_fail_info}, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_cfg_ready_back", {127'd0, d_cfg_ready}, 128'd1);
    start_pulse();
    wait_done("empty_done", 1'b0, 4);
    chk("empty_pass_cnt", {112'd0, d_pass_cnt}, 128'd0);
    chk("empty_timeout", {127'd0, d_timeout}, 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
